glb_host_arbiter: RTL and testbench
===================================

Name: glb_host_arbiter

Overview:
- Shares the single global_buffer host port (host_wr_*/host_rd_*) between NUM_REQ requesters, e.g. the host interface, a config loader and a debug reader.
- Per-requester valid/ready request channels; round-robin grant; one access (read or write) issued per cycle.
- Read data returns over a fixed-latency path and is routed back to the requester that issued the read, tracked by a requester-ID shift pipeline.
- Sits directly in front of global_buffer; its glb_* outputs connect to the buffer's host_* ports.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 32, host address width.
- DATA_W, 64, host data width.
- STRB_W, 8, write strobe width (DATA_W/8).
- RD_LATENCY, 2, cycles from glb_rd_en asserted to valid glb_rd_data (1..4).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (the grant).
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_strb  in  NUM_REQ*STRB_W  write strobes, requester i in slice [i*STRB_W +: STRB_W].
- req_addr  in  NUM_REQ*ADDR_W  address, sliced the same way.
- req_wdata  in  NUM_REQ*DATA_W  write data, sliced the same way.
- rsp_valid  out  NUM_REQ  read response valid for requester i.
- rsp_data  out  DATA_W  read response data, shared by all requesters.
- glb_wr_strb  out  STRB_W  to global_buffer host_wr_strb.
- glb_wr_addr  out  ADDR_W  to host_wr_addr.
- glb_wr_data  out  DATA_W  to host_wr_data.
- glb_rd_en  out  1  to host_rd_en.
- glb_rd_addr  out  ADDR_W  to host_rd_addr.
- glb_rd_data  in  DATA_W  from host_rd_data.

Behaviour:
- Reset (reset=0, asynchronous):
  - All glb_* outputs, rsp_valid and rsp_data go to 0.
  - The ID/valid pipeline is cleared.
  - The round-robin pointer last_grant = NUM_REQ-1, so requester 0 has highest priority after reset.
- Grant (combinational, same cycle):
  - Scan requesters starting at (last_grant+1) mod NUM_REQ, wrapping; the first with req_valid=1 wins.
  - req_ready is one-hot or zero; a handshake is req_valid & req_ready.
  - On a handshake, last_grant <= winner; with no handshake, last_grant holds.
- A requester must hold valid and payload stable until ready. No combinational path exists from req_ready to req_valid.
- Issue (registered, one cycle after handshake):
  - Write: glb_wr_strb/addr/data <= winner's payload for exactly one cycle, then glb_wr_strb returns to 0.
  - Read: glb_rd_en=1 and glb_rd_addr <= winner's address for one cycle.
  - glb_wr_strb and glb_rd_en are never both nonzero.
  - glb_wr_addr, glb_wr_data and glb_rd_addr hold their last values when idle.
  - A write with strb=0 is still accepted but issues no access (glb_wr_strb stays 0) and produces no response.
- Response:
  - Each issued read pushes {valid, winner ID} into a pipeline of depth RD_LATENCY + 1.
  - Exactly RD_LATENCY+1 cycles after the issuing glb_rd_en cycle, rsp_valid[id] is high for one cycle.
  - rsp_data is registered glb_rd_data sampled RD_LATENCY cycles after glb_rd_en.
  - Total read latency from handshake to rsp_valid is RD_LATENCY+2 cycles.
- Throughput: one handshake per cycle sustained. Back-to-back reads from different requesters return in issue order, one per cycle. No backpressure exists on the response path; a requester must always accept rsp_valid.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... and no requester waits more than NUM_REQ-1 cycles.
- Simultaneous read and write from different requesters are serialised by the arbiter. A read issued the cycle after a write to the same address returns the new data.
- Reset mid-operation: in-flight reads are dropped and no rsp_valid is produced after reset release for reads issued before reset.

Decomposition:
- Shared package glb_pkg:
  - GLB_ADDR_W, GLB_DATA_W, GLB_STRB_W constants.
  - typedef glb_req_t {wr, strb, addr, wdata}.
  - RD_LATENCY default, matching global_buffer.
- Sub-module rr_arbiter (parameter N): req vector in, one-hot grant out, internal last_grant pointer, update on an accept input.
- The top level holds the payload mux, issue registers and ID pipeline.

Test Plan:
- Single write then read: req0 writes addr 0x0F, data 0x12345678, strb 0xFF; req0 then reads 0x0F -> glb_wr_strb=0xFF for one cycle; rsp_valid[0] at handshake+RD_LATENCY+2 with rsp_data=0x12345678.
- Round-robin: all three requesters held valid for 6 cycles after reset -> grant order 0,1,2,0,1,2; each req_ready one-hot.
- Read routing: req1 reads 0x10 and req2 reads 0x20 in consecutive cycles, memory preloaded with 0xA and 0xB -> rsp_valid[1] with 0xA, then next cycle rsp_valid[2] with 0xB.
- Zero strobe: req0 write with strb=0 -> req_ready[0]=1, glb_wr_strb stays 0, memory unchanged, no rsp_valid.
- Reset mid-read: req0 read handshake, then reset pulled low for one cycle -> all outputs 0 immediately; no rsp_valid after release; next grant goes to req0.
- Write/read ordering: req0 writes 0xDEAD to 0x30 and req1 reads 0x30 the same cycle -> req0 granted first; req1 receives 0xDEAD.

Source files
------------

// File: rtl/glb_pkg.sv
// Shared constants and request payload type for the global_buffer host port.
package glb_pkg;

    localparam int unsigned GLB_ADDR_W     = 32;
    localparam int unsigned GLB_DATA_W     = 64;
    localparam int unsigned GLB_STRB_W     = GLB_DATA_W / 8;
    localparam int unsigned GLB_RD_LATENCY = 2;

    typedef struct packed {
        logic                  wr;
        logic [GLB_STRB_W-1:0] strb;
        logic [GLB_ADDR_W-1:0] addr;
        logic [GLB_DATA_W-1:0] wdata;
    } glb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, scanning from the requester after the last winner.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_grant;
    logic [PW-1:0] winner;
    logic [PW-1:0] idx_w;
    logic          found;
    int unsigned   idx;

    always_comb begin
        grant  = '0;
        winner = last_grant;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // last_grant < N and k < N, so a single wrap subtraction is enough
            idx = 32'(last_grant) + 32'd1 + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = PW'(idx);
            if (!found && req[idx_w]) begin
                found        = 1'b1;
                grant[idx_w] = 1'b1;
                winner       = idx_w;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= PW'(N - 1);
        end else if (accept) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/glb_host_arbiter.sv
// Shares the global_buffer host port between NUM_REQ requesters; reads are routed back
// to their issuer through a fixed-latency requester-ID pipeline.
module glb_host_arbiter
    import glb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_W     = GLB_ADDR_W,
    parameter int unsigned DATA_W     = GLB_DATA_W,
    parameter int unsigned STRB_W     = GLB_STRB_W,
    parameter int unsigned RD_LATENCY = GLB_RD_LATENCY
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*STRB_W-1:0] req_strb,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [STRB_W-1:0]         glb_wr_strb,
    output logic [ADDR_W-1:0]         glb_wr_addr,
    output logic [DATA_W-1:0]         glb_wr_data,
    output logic                      glb_rd_en,
    output logic [ADDR_W-1:0]         glb_rd_addr,
    input  logic [DATA_W-1:0]         glb_rd_data
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] grant;
    logic               hs;
    logic [IW-1:0]      win_id;
    glb_req_t           sel;

    logic [RD_LATENCY:0]         pipe_vld;
    logic [RD_LATENCY:0][IW-1:0] pipe_id;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .accept(hs),
        .grant (grant)
    );

    assign req_ready = grant;
    assign hs        = |grant;

    // Payload mux driven by the one-hot grant
    always_comb begin
        win_id = '0;
        sel    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_id    = IW'(i);
                sel.wr    = req_wr[i];
                sel.strb  = req_strb[i*STRB_W +: STRB_W];
                sel.addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel.wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Issue registers: strobe / read-enable pulse for one cycle, addresses and data hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glb_wr_strb <= '0;
            glb_wr_addr <= '0;
            glb_wr_data <= '0;
            glb_rd_en   <= 1'b0;
            glb_rd_addr <= '0;
        end else begin
            glb_wr_strb <= '0;
            glb_rd_en   <= 1'b0;
            if (hs) begin
                if (sel.wr) begin
                    if (|sel.strb) begin
                        glb_wr_strb <= sel.strb;
                        glb_wr_addr <= sel.addr;
                        glb_wr_data <= sel.wdata;
                    end
                end else begin
                    glb_rd_en   <= 1'b1;
                    glb_rd_addr <= sel.addr;
                end
            end
        end
    end

    // Stage 0 lines up with glb_rd_en; stage RD_LATENCY lines up with valid glb_rd_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            pipe_vld <= {pipe_vld[RD_LATENCY-1:0], hs & ~sel.wr};
            pipe_id  <= {pipe_id[RD_LATENCY-1:0], win_id};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (pipe_vld[RD_LATENCY]) begin
                rsp_valid[pipe_id[RD_LATENCY]] <= 1'b1;
                rsp_data                       <= glb_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_glb_host_arbiter.sv
// Directed bench for glb_host_arbiter with a small behavioural global_buffer stand-in.
module tb_glb_host_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 8;
    localparam int unsigned L  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wr;
    logic [N*SW-1:0] req_strb;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [SW-1:0]   glb_wr_strb;
    logic [AW-1:0]   glb_wr_addr;
    logic [DW-1:0]   glb_wr_data;
    logic            glb_rd_en;
    logic [AW-1:0]   glb_rd_addr;
    logic [DW-1:0]   glb_rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    glb_host_arbiter #(
        .NUM_REQ   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STRB_W    (SW),
        .RD_LATENCY(L)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_strb   (req_strb),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .glb_wr_strb(glb_wr_strb),
        .glb_wr_addr(glb_wr_addr),
        .glb_wr_data(glb_wr_data),
        .glb_rd_en  (glb_rd_en),
        .glb_rd_addr(glb_rd_addr),
        .glb_rd_data(glb_rd_data)
    );

    // Buffer model: byte-strobed writes, read data valid L cycles after glb_rd_en
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] rd_pipe [0:L-1];

    always @(posedge clk) begin
        for (int b = 0; b < SW; b++) begin
            if (glb_wr_strb[b]) mem[glb_wr_addr[7:0]][b*8 +: 8] <= glb_wr_data[b*8 +: 8];
        end
        if (glb_rd_en) rd_pipe[0] <= mem[glb_rd_addr[7:0]];
        for (int s = 1; s < L; s++) rd_pipe[s] <= rd_pipe[s-1];
    end

    assign glb_rd_data = rd_pipe[L-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic wr, input logic [7:0] s,
                           input logic [31:0] a, input logic [63:0] d);
        req_valid[i]          = v;
        req_wr[i]             = wr;
        req_strb[i*SW +: SW]  = s;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic rsp_idle(input string tag);
        chk(tag, {61'd0, rsp_valid}, 64'd0);
    endtask

    logic [2:0] rr_exp [0:5];

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        reset     = 1'b0;
        req_valid = '0;
        req_wr    = '0;
        req_strb  = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_strb", {56'd0, glb_wr_strb}, 64'd0);
        chk("rst_rd_en", {63'd0, glb_rd_en}, 64'd0);
        chk("rst_rsp_valid", {61'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_wr_addr", {32'd0, glb_wr_addr}, 64'd0);
        reset = 1'b1;
        tick();
        chk("idle_ready", {61'd0, req_ready}, 64'd0);

        // Single write then read by req0
        set_req(0, 1, 1, 8'hFF, 32'h0F, 64'h12345678);
        #1 chk("t1_wr_ready", {61'd0, req_ready}, 64'h1);
        tick();
        chk("t1_wr_strb", {56'd0, glb_wr_strb}, 64'hFF);
        chk("t1_wr_addr", {32'd0, glb_wr_addr}, 64'h0F);
        chk("t1_wr_data", glb_wr_data, 64'h12345678);
        chk("t1_wr_no_rd", {63'd0, glb_rd_en}, 64'd0);
        set_req(0, 1, 0, 8'h00, 32'h0F, 64'd0);
        #1 chk("t1_rd_ready", {61'd0, req_ready}, 64'h1);
        tick();
        chk("t1_strb_clear", {56'd0, glb_wr_strb}, 64'd0);
        chk("t1_rd_en", {63'd0, glb_rd_en}, 64'h1);
        chk("t1_rd_addr", {32'd0, glb_rd_addr}, 64'h0F);
        req_valid = '0;
        tick();
        chk("t1_rd_en_clear", {63'd0, glb_rd_en}, 64'd0);
        rsp_idle("t1_rsp_early3");
        tick();
        rsp_idle("t1_rsp_early4");
        tick();
        chk("t1_rsp_valid", {61'd0, rsp_valid}, 64'h1);
        chk("t1_rsp_data", rsp_data, 64'h12345678);
        tick();
        rsp_idle("t1_rsp_once");

        // Round-robin with all requesters continuously valid after reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 1, 0, 8'h00, 32'h40 + 32'(i), 64'd0);
        for (int k = 0; k < 6; k++) begin
            #1 chk($sformatf("rr_grant%0d", k), {61'd0, req_ready}, {61'd0, rr_exp[k]});
            tick();
        end
        req_valid = '0;
        repeat (6) tick();

        // Read routing: preload via req0 writes, then req1 and req2 read back to back
        set_req(0, 1, 1, 8'hFF, 32'h10, 64'hA);
        #1 chk("t3_pre1_ready", {61'd0, req_ready}, 64'h1);
        tick();
        set_req(0, 1, 1, 8'hFF, 32'h20, 64'hB);
        #1 chk("t3_pre2_ready", {61'd0, req_ready}, 64'h1);
        tick();
        req_valid = '0;
        tick();
        set_req(1, 1, 0, 8'h00, 32'h10, 64'd0);
        #1 chk("t3_r1_ready", {61'd0, req_ready}, 64'h2);
        tick();
        chk("t3_r1_addr", {32'd0, glb_rd_addr}, 64'h10);
        req_valid = '0;
        set_req(2, 1, 0, 8'h00, 32'h20, 64'd0);
        #1 chk("t3_r2_ready", {61'd0, req_ready}, 64'h4);
        tick();
        chk("t3_r2_rd_en", {63'd0, glb_rd_en}, 64'h1);
        chk("t3_r2_addr", {32'd0, glb_rd_addr}, 64'h20);
        req_valid = '0;
        tick();
        rsp_idle("t3_rsp_early");
        tick();
        chk("t3_rsp1_valid", {61'd0, rsp_valid}, 64'h2);
        chk("t3_rsp1_data", rsp_data, 64'hA);
        tick();
        chk("t3_rsp2_valid", {61'd0, rsp_valid}, 64'h4);
        chk("t3_rsp2_data", rsp_data, 64'hB);
        tick();
        rsp_idle("t3_rsp_done");

        // Zero-strobe write is accepted but changes nothing
        set_req(0, 1, 1, 8'h00, 32'h10, 64'hFFFF);
        #1 chk("t4_ready", {61'd0, req_ready}, 64'h1);
        tick();
        chk("t4_no_strb", {56'd0, glb_wr_strb}, 64'd0);
        chk("t4_no_rd", {63'd0, glb_rd_en}, 64'd0);
        rsp_idle("t4_rsp1");
        set_req(0, 1, 0, 8'h00, 32'h10, 64'd0);
        #1 chk("t4_rd_ready", {61'd0, req_ready}, 64'h1);
        tick();
        req_valid = '0;
        rsp_idle("t4_rsp2");
        tick();
        rsp_idle("t4_rsp3");
        tick();
        rsp_idle("t4_rsp4");
        tick();
        chk("t4_rsp_valid", {61'd0, rsp_valid}, 64'h1);
        chk("t4_mem_kept", rsp_data, 64'hA);
        tick();

        // Write/read ordering: req0 write and req1 read to the same address together
        set_req(2, 1, 1, 8'h00, 32'h00, 64'd0);
        #1 chk("t5_pos_ready", {61'd0, req_ready}, 64'h4);
        tick();
        req_valid = '0;
        set_req(0, 1, 1, 8'hFF, 32'h30, 64'hDEAD);
        set_req(1, 1, 0, 8'h00, 32'h30, 64'd0);
        #1 chk("t5_wr_first", {61'd0, req_ready}, 64'h1);
        tick();
        chk("t5_wr_strb", {56'd0, glb_wr_strb}, 64'hFF);
        chk("t5_wr_data", glb_wr_data, 64'hDEAD);
        req_valid[0] = 1'b0;
        #1 chk("t5_rd_second", {61'd0, req_ready}, 64'h2);
        tick();
        chk("t5_rd_en", {63'd0, glb_rd_en}, 64'h1);
        chk("t5_excl", {56'd0, glb_wr_strb}, 64'd0);
        req_valid = '0;
        tick();
        rsp_idle("t5_rsp_early3");
        tick();
        rsp_idle("t5_rsp_early4");
        tick();
        chk("t5_rsp_valid", {61'd0, rsp_valid}, 64'h2);
        chk("t5_rsp_data", rsp_data, 64'hDEAD);
        tick();

        // Reset mid-read drops the in-flight response
        set_req(0, 1, 0, 8'h00, 32'h30, 64'd0);
        #1 chk("t6_ready", {61'd0, req_ready}, 64'h1);
        tick();
        chk("t6_rd_en", {63'd0, glb_rd_en}, 64'h1);
        req_valid = '0;
        reset = 1'b0;
        #1;
        chk("t6_rst_rd_en", {63'd0, glb_rd_en}, 64'd0);
        chk("t6_rst_rd_addr", {32'd0, glb_rd_addr}, 64'd0);
        chk("t6_rst_wr_addr", {32'd0, glb_wr_addr}, 64'd0);
        chk("t6_rst_wr_data", glb_wr_data, 64'd0);
        chk("t6_rst_rsp_data", rsp_data, 64'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            rsp_idle($sformatf("t6_no_rsp%0d", k));
        end
        for (int i = 0; i < 3; i++) set_req(i, 1, 0, 8'h00, 32'h50, 64'd0);
        #1 chk("t6_next_grant", {61'd0, req_ready}, 64'h1);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
